// File: rtl/camera_ring_scheduler_pkg.sv
// Shared state codes and index helpers for the N-camera filming scheduler.
package camera_ring_scheduler_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    CAM_IDLE    = 3'd0,
    CAM_STANDBY = 3'd1,
    CAM_FILM    = 3'd2,
    CAM_HOLD    = 3'd3,
    CAM_DRAIN   = 3'd4,
    CAM_FLUSH   = 3'd5
  } camState_t;

  // Camera index reached by stepping 'off' positions after 'base' around the ring.
  function automatic int wrapIdx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/camera_ring_scheduler_channel.sv
// One camera: state register plus fill-level counter, steered by the ring scheduler.
module camera_channel
  import camera_ring_scheduler_pkg::*;
#(
  parameter int LEVEL_W    = 4,
  parameter int FULL_LEVEL = 10,
  parameter bit IS_START   = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               goStandby,
  input  logic               goFilm,
  input  logic               goHold,
  input  logic               goFlush,
  input  logic               downloadReq,
  output camState_t          state,
  output logic [LEVEL_W-1:0] level
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IS_START ? CAM_FILM : CAM_IDLE;
      level <= '0;
    end else begin
      case (state)
        CAM_IDLE:    if (goStandby) state <= CAM_STANDBY;
        CAM_STANDBY: if (goFilm) state <= CAM_FILM;
        CAM_FILM: begin
          if (goHold) state <= CAM_HOLD;
          if (tick && level < LEVEL_W'(FULL_LEVEL)) level <= level + 1'b1;
        end
        // A download request beats a flush raised on the same cycle.
        CAM_HOLD: begin
          if (downloadReq)  state <= CAM_DRAIN;
          else if (goFlush) state <= CAM_FLUSH;
        end
        CAM_DRAIN: begin
          if (level == '0) state <= CAM_IDLE;
          else if (tick)   level <= level - 1'b1;
        end
        CAM_FLUSH: begin
          state <= CAM_IDLE;
          level <= '0;
        end
        default: state <= CAM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/camera_ring_scheduler.sv
// Round-robin filming scheduler: one camera films, the next IDLE one is readied, full ones are held.
module camera_ring_scheduler
  import camera_ring_scheduler_pkg::*;
#(
  parameter int NUM_CAMS      = 4,
  parameter int LEVEL_W       = 4,
  parameter int FULL_LEVEL    = 10,
  parameter int STANDBY_LEVEL = 8,
  parameter int HANDOFF_LEVEL = 9,
  parameter int FLUSH_LEVEL   = 5,
  parameter int START_CAM     = 0,
  localparam int IDX_W        = $clog2(NUM_CAMS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic [NUM_CAMS-1:0]         download_req,
  output logic [NUM_CAMS*LEVEL_W-1:0] level,
  output logic [NUM_CAMS*3-1:0]       cam_state,
  output logic [NUM_CAMS-1:0]         filming,
  output logic [NUM_CAMS-1:0]         standby,
  output logic [NUM_CAMS-1:0]         ready_dl,
  output logic [IDX_W-1:0]            active_idx,
  output logic                        overflow_err
);

  camState_t          camStates [NUM_CAMS];
  logic [LEVEL_W-1:0] camLevels [NUM_CAMS];
  logic [NUM_CAMS-1:0] goStandby, goFilm, goHold, goFlush;

  logic [IDX_W-1:0]   prevIdx;
  logic [IDX_W-1:0]   standbyIdx;
  logic [IDX_W-1:0]   standbyPick;
  logic               standbyFound;
  logic               standbyAny;
  logic               activeFilm;
  logic [LEVEL_W-1:0] activeLevel;
  logic               handoff;

  for (genvar i = 0; i < NUM_CAMS; i++) begin : g_cam
    camera_channel #(
      .LEVEL_W   (LEVEL_W),
      .FULL_LEVEL(FULL_LEVEL),
      .IS_START  (i == START_CAM)
    ) u_channel (
      .clock      (clock),
      .reset_n    (reset_n),
      .tick       (tick),
      .goStandby  (goStandby[i]),
      .goFilm     (goFilm[i]),
      .goHold     (goHold[i]),
      .goFlush    (goFlush[i]),
      .downloadReq(download_req[i]),
      .state      (camStates[i]),
      .level      (camLevels[i])
    );

    assign level[i*LEVEL_W +: LEVEL_W] = camLevels[i];
    assign cam_state[i*3 +: 3]         = camStates[i];
    assign filming[i]                  = (camStates[i] == CAM_FILM);
    assign standby[i]                  = (camStates[i] == CAM_STANDBY);
    assign ready_dl[i]                 = (camStates[i] == CAM_HOLD);
  end

  always_comb begin
    activeLevel  = camLevels[active_idx];
    activeFilm   = (camStates[active_idx] == CAM_FILM);
    standbyAny   = |standby;
    standbyIdx   = '0;
    standbyFound = 1'b0;
    standbyPick  = '0;
    for (int k = 0; k < NUM_CAMS; k++) begin
      if (standby[k]) standbyIdx = IDX_W'(k);
    end
    // First IDLE camera after the active one, wrapping around the ring.
    for (int k = 1; k < NUM_CAMS; k++) begin
      if (!standbyFound && camStates[wrapIdx(int'(active_idx), k, NUM_CAMS)] == CAM_IDLE) begin
        standbyFound = 1'b1;
        standbyPick  = IDX_W'(wrapIdx(int'(active_idx), k, NUM_CAMS));
      end
    end

    handoff      = activeFilm && (activeLevel >= LEVEL_W'(HANDOFF_LEVEL)) && standbyAny;
    overflow_err = activeFilm && (activeLevel == LEVEL_W'(FULL_LEVEL)) && !standbyAny;

    goStandby = '0;
    goFilm    = '0;
    goHold    = '0;
    goFlush   = '0;
    goStandby[standbyPick] = activeFilm && (activeLevel >= LEVEL_W'(STANDBY_LEVEL)) &&
                             !standbyAny && standbyFound;
    goHold[active_idx]     = handoff;
    goFilm[standbyIdx]     = handoff;
    // Only the most recent predecessor is ever flushed.
    goFlush[prevIdx]       = (activeLevel >= LEVEL_W'(FLUSH_LEVEL)) &&
                             (camStates[prevIdx] == CAM_HOLD) && !download_req[prevIdx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_idx <= IDX_W'(START_CAM);
      prevIdx    <= IDX_W'(START_CAM);
    end else if (handoff) begin
      prevIdx    <= active_idx;
      active_idx <= standbyIdx;
    end
  end

endmodule
